// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI initiator (spi_master_ctrl).
package spi_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SHIFT = 3'd2,
        TURN  = 3'd3,
        RECV  = 3'd4,
        GAP   = 3'd5
    } spi_mst_state_e;

    // Largest of four state durations.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        m = (b > m) ? b : m;
        m = (c > m) ? c : m;
        m = (d > m) ? d : m;
        return m;
    endfunction

    // Width of the per-state down counter; it only ever holds (duration - 1)
    // of the longest state, so it never needs to wrap.
    function automatic int cnt_width(input int w, input int a, input int t, input int g);
        return $clog2(max4(w, a, t, g) + 1);
    endfunction

endpackage

// File: rtl/spi_mst_shifter.sv
// Datapath of the SPI initiator: parallel-load PISO feeding MOSI, SIPO
// collecting MISO, and the down counter shared by every timed FSM state.
module spi_mst_shifter #(
    parameter int W     = 10,
    parameter int RX_W  = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic             shift_en,
    input  logic             mosi_clr,
    input  logic             cnt_load,
    input  logic [CNT_W-1:0] cnt_val,
    input  logic             cnt_dec,
    input  logic             rx_en,
    input  logic             miso,
    output logic             cnt_zero,
    output logic             mosi,
    output logic [RX_W-1:0]  rx_word
);

    logic [W-1:0]      tx_r;
    logic              mosi_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [RX_W-2:0]   rx_r;

    // Transmit path: load presents the MSB at once (START bit), each shift
    // re-presents the current MSB and moves the word left; clear parks MOSI low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r   <= {W{1'b0}};
            mosi_r <= 1'b0;
        end else if (load) begin
            tx_r   <= load_data;
            mosi_r <= load_data[W-1];
        end else if (shift_en) begin
            mosi_r <= tx_r[W-1];
            tx_r   <= {tx_r[W-2:0], 1'b0};
        end else if (mosi_clr) begin
            mosi_r <= 1'b0;
        end else begin
            mosi_r <= mosi_r;
        end
    end

    // State-duration counter: reloaded on entry to each timed state, counts to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_load) begin
            cnt_r <= cnt_val;
        end else if (cnt_dec) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Receive path: MISO is only shifted in while enabled, so idle-line X/Z never lands here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_r <= {(RX_W-1){1'b0}};
        end else if (rx_en) begin
            rx_r <= rx_word[RX_W-2:0];
        end else begin
            rx_r <= rx_r;
        end
    end

    // rx_word already includes the bit on MISO this cycle, so the byte is
    // complete on the final receive edge.
    assign rx_word  = {rx_r, miso};
    assign cnt_zero = (cnt_r == {CNT_W{1'b0}});
    assign mosi     = mosi_r;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator: takes one RAM command word per frame, serialises it MSB
// first on SS_n/MOSI and, for read-data frames, collects the returned byte
// from MISO and presents it on rsp_data with a one-cycle rsp_valid pulse.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int  MEM_DEPTH     = 256,
    parameter int  RD_TURNAROUND = 2,   // must be >= 1
    parameter int  IDLE_GAP      = 1,   // must be >= 1
    localparam int ADDR_SIZE     = $clog2(MEM_DEPTH),
    localparam int W             = ADDR_SIZE + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [W-1:0]         cmd_data,
    output logic                 rsp_valid,
    output logic [ADDR_SIZE-1:0] rsp_data,
    output logic                 busy,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int CNT_W = cnt_width(W, ADDR_SIZE, RD_TURNAROUND, IDLE_GAP);

    localparam logic [CNT_W-1:0] SHIFT_INI = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] TURN_INI  = CNT_W'(RD_TURNAROUND - 1);
    localparam logic [CNT_W-1:0] RECV_INI  = CNT_W'(ADDR_SIZE - 1);
    localparam logic [CNT_W-1:0] GAP_INI   = CNT_W'(IDLE_GAP - 1);

    spi_mst_state_e        state_r;
    spi_mst_state_e        state_nxt_s;
    spi_op_e               op_r;

    logic                  accept_s;
    logic                  shift_en_s;
    logic                  mosi_clr_s;
    logic                  cnt_load_s;
    logic [CNT_W-1:0]      cnt_val_s;
    logic                  cnt_dec_s;
    logic                  cnt_zero_s;
    logic                  rx_en_s;
    logic                  rsp_fire_s;
    logic                  ss_n_nxt_s;
    logic [ADDR_SIZE-1:0]  rx_word_s;
    logic                  mosi_s;

    logic                  ss_n_r;
    logic                  cmd_ready_r;
    logic                  busy_r;
    logic                  rsp_valid_r;
    logic [ADDR_SIZE-1:0]  rsp_data_r;

    spi_mst_shifter #(
        .W     (W),
        .RX_W  (ADDR_SIZE),
        .CNT_W (CNT_W)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept_s),
        .load_data (cmd_data),
        .shift_en  (shift_en_s),
        .mosi_clr  (mosi_clr_s),
        .cnt_load  (cnt_load_s),
        .cnt_val   (cnt_val_s),
        .cnt_dec   (cnt_dec_s),
        .rx_en     (rx_en_s),
        .miso      (MISO),
        .cnt_zero  (cnt_zero_s),
        .mosi      (mosi_s),
        .rx_word   (rx_word_s)
    );

    // Next-state and datapath control for the frame sequencer.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        shift_en_s  = 1'b0;
        mosi_clr_s  = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_val_s   = {CNT_W{1'b0}};
        cnt_dec_s   = 1'b0;
        rx_en_s     = 1'b0;
        rsp_fire_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                shift_en_s  = 1'b1;
                cnt_load_s  = 1'b1;
                cnt_val_s   = SHIFT_INI;
                state_nxt_s = SHIFT;
            end
            SHIFT: begin
                if (cnt_zero_s) begin
                    mosi_clr_s = 1'b1;
                    cnt_load_s = 1'b1;
                    if (op_r == RD_DATA) begin
                        cnt_val_s   = TURN_INI;
                        state_nxt_s = TURN;
                    end else begin
                        cnt_val_s   = GAP_INI;
                        state_nxt_s = GAP;
                    end
                end else begin
                    shift_en_s = 1'b1;
                    cnt_dec_s  = 1'b1;
                end
            end
            TURN: begin
                if (cnt_zero_s) begin
                    cnt_load_s  = 1'b1;
                    cnt_val_s   = RECV_INI;
                    state_nxt_s = RECV;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            RECV: begin
                rx_en_s = 1'b1;
                if (cnt_zero_s) begin
                    rsp_fire_s  = 1'b1;
                    cnt_load_s  = 1'b1;
                    cnt_val_s   = GAP_INI;
                    state_nxt_s = GAP;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            GAP: begin
                if (cnt_zero_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Slave select is low for every state that belongs to an active frame.
    always_comb begin
        ss_n_nxt_s = 1'b1;
        case (state_nxt_s)
            START, SHIFT, TURN, RECV: ss_n_nxt_s = 1'b0;
            default:                  ss_n_nxt_s = 1'b1;
        endcase
    end

    // FSM state and the opcode of the frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            op_r    <= WR_ADDR;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                op_r <= spi_op_e'(cmd_data[W-1 -: 2]);
            end else begin
                op_r <= op_r;
            end
        end
    end

    // Output registers, driven from the state being entered so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n_r      <= 1'b1;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {ADDR_SIZE{1'b0}};
        end else begin
            ss_n_r      <= ss_n_nxt_s;
            cmd_ready_r <= (state_nxt_s == IDLE);
            busy_r      <= (state_nxt_s != IDLE);
            rsp_valid_r <= rsp_fire_s;
            if (rsp_fire_s) begin
                rsp_data_r <= rx_word_s;
            end else begin
                rsp_data_r <= rsp_data_r;
            end
        end
    end

    assign SS_n      = ss_n_r;
    assign MOSI      = mosi_s;
    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: a table of single commands
// against a small SPI-slave RAM model, plus hand sequences for
// back-to-back frames, reset mid-frame and a longer turnaround.
module tb_spi_master_ctrl;

    localparam int W  = 10;
    localparam int A  = 8;
    localparam int T  = 2;
    localparam int T3 = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid, cmd_ready, rsp_valid, busy, ss_n, mosi, miso;
    logic [W-1:0] cmd_data;
    logic [A-1:0] rsp_data;
    logic         cmd_valid3, cmd_ready3, rsp_valid3, busy3, ss_n3, mosi3, miso3;
    logic [W-1:0] cmd_data3;
    logic [A-1:0] rsp_data3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_master_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
    );

    spi_master_ctrl #(.RD_TURNAROUND(T3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_data(cmd_data3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .busy(busy3),
        .SS_n(ss_n3), .MOSI(mosi3), .MISO(miso3)
    );

    // ---------------- slave RAM model + frame monitor for dut ----------------
    int           lowcnt = 0, cur = 0, last_len = 0, frames = 0, rsp_cnt = 0;
    int           hicnt = 0, min_hi = 1000, hs_viol = 0, rsp_timing_bad = 0;
    logic         ss_prev = 1'b1;
    logic [W-1:0] frame_word = '0, last_word = '0;
    logic [W-1:0] word_log[$];
    logic         mosi_seq[0:31];
    logic [A-1:0] mem[0:255];
    logic [A-1:0] m_wa = '0, m_ra = '0, rd_byte = '0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 32; i++) mosi_seq[i] = 1'b0;
    end

    always @(negedge clk) begin
        if (cmd_ready == busy) hs_viol++;
        if (rsp_valid) begin
            rsp_cnt++;
            if (!(ss_n && !ss_prev)) rsp_timing_bad++;
        end
        if (!ss_n) begin
            if (lowcnt == 0 && hicnt < min_hi) min_hi = hicnt;
            cur = lowcnt;
            lowcnt++;
            hicnt = 0;
            if (cur < 32) mosi_seq[cur] = mosi;
            if (cur >= 1 && cur <= W) frame_word = {frame_word[W-2:0], mosi};
            if (cur == W) begin
                last_word = frame_word;
                word_log.push_back(frame_word);
                case (frame_word[W-1:W-2])
                    2'b00:   m_wa = frame_word[A-1:0];
                    2'b01:   mem[m_wa] = frame_word[A-1:0];
                    2'b10:   m_ra = frame_word[A-1:0];
                    default: rd_byte = mem[m_ra];
                endcase
            end
            if (cur >= 1 + W + T && cur < 1 + W + T + A) miso = rd_byte[A - 1 - (cur - (1 + W + T))];
            else miso = 1'b1;
        end else begin
            if (lowcnt > 0) begin
                last_len = lowcnt;
                frames++;
            end
            lowcnt = 0;
            hicnt++;
            miso = 1'b1;
        end
        ss_prev = ss_n;
    end

    // ---------------- fixed-byte slave for dut3 ----------------
    int           lowcnt3 = 0, cur3 = 0, last_len3 = 0, rsp_cnt3 = 0;
    logic [A-1:0] byte3 = 8'h5A;

    always @(negedge clk) begin
        if (rsp_valid3) rsp_cnt3++;
        if (!ss_n3) begin
            cur3 = lowcnt3;
            lowcnt3++;
            if (cur3 >= 1 + W + T3 && cur3 < 1 + W + T3 + A) miso3 = byte3[A - 1 - (cur3 - (1 + W + T3))];
            else miso3 = 1'b1;
        end else begin
            if (lowcnt3 > 0) last_len3 = lowcnt3;
            lowcnt3 = 0;
            miso3 = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One command to dut: wait for ready, offer for one cycle, wait for idle.
    task automatic send(input logic [W-1:0] c);
        int g;
        g = 0;
        @(negedge clk);
        while (!cmd_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("ready_wait", (g < 200), 1);
        cmd_valid = 1'b1;
        cmd_data  = c;
        @(negedge clk);
        cmd_valid = 1'b0;
        g = 0;
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("frame_done", (g < 200), 1);
    endtask

    typedef struct {
        logic [W-1:0] cmd;
        int           len;
        int           rv;
        logic [A-1:0] rd;
    } vec_t;

    vec_t         tbl[9];
    logic [W-1:0] b2b[4];
    logic [10:0]  exp_t2, got_t2;
    int           r0, f0, k, g;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; cmd_valid3 = 1'b0; cmd_data3 = '0;

        // 1: reset state, then unchanged after release
        repeat (3) @(negedge clk);
        check("reset_outputs", {ss_n, cmd_ready, rsp_valid, busy, mosi, rsp_data}, {5'b11000, 8'h00});
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_outputs", {ss_n, cmd_ready, rsp_valid, busy, mosi, rsp_data}, {5'b11000, 8'h00});

        // 2/3 and table: cmd, SS_n low length, rsp pulses, rsp_data afterwards
        tbl[0] = '{10'h03A, 11, 0, 8'h00};
        tbl[1] = '{10'h1C4, 11, 0, 8'h00};
        tbl[2] = '{10'h23A, 11, 0, 8'h00};
        tbl[3] = '{10'h300, 21, 1, 8'hC4};
        tbl[4] = '{10'h0A5, 11, 0, 8'hC4};
        tbl[5] = '{10'h17F, 11, 0, 8'hC4};
        tbl[6] = '{10'h2A5, 11, 0, 8'hC4};
        tbl[7] = '{10'h300, 21, 1, 8'h7F};
        tbl[8] = '{10'h3FF, 21, 1, 8'h7F};
        exp_t2 = 11'b00000111010;
        for (int i = 0; i < 9; i++) begin
            r0 = rsp_cnt;
            send(tbl[i].cmd);
            check($sformatf("len[%0d]", i), last_len, tbl[i].len);
            check($sformatf("rsp_pulses[%0d]", i), rsp_cnt - r0, tbl[i].rv);
            check($sformatf("rsp_data[%0d]", i), rsp_data, tbl[i].rd);
            check($sformatf("frame_word[%0d]", i), last_word, tbl[i].cmd);
            check($sformatf("start_bit[%0d]", i), mosi_seq[0], tbl[i].cmd[W-1]);
            if (i == 0) begin
                for (int j = 0; j < 11; j++) got_t2[10-j] = mosi_seq[j];
                check("mosi_seq_03A", got_t2, exp_t2);
            end
        end

        // 4: cmd_valid held high, back-to-back frames
        b2b[0] = 10'h0A5; b2b[1] = 10'h133; b2b[2] = 10'h2A5; b2b[3] = 10'h300;
        word_log.delete();
        min_hi = 1000; f0 = frames; r0 = rsp_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        k = 0; g = 0;
        while (k < 4 && g < 400) begin
            if (cmd_ready) begin
                cmd_data = b2b[k];
                k++;
            end
            @(negedge clk);
            g++;
        end
        cmd_valid = 1'b0;
        g = 0;
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("b2b_done", (g < 200), 1);
        check("b2b_frames", frames - f0, 4);
        check("b2b_log_size", word_log.size(), 4);
        for (int j = 0; j < 4; j++)
            check($sformatf("b2b_word[%0d]", j), (j < word_log.size()) ? word_log[j] : 10'h000, b2b[j]);
        check("b2b_gap_min", (min_hi >= 1), 1);
        check("b2b_rsp_pulses", rsp_cnt - r0, 1);
        check("b2b_rsp_data", rsp_data, 8'h33);
        check("ready_vs_busy", hs_viol, 0);
        check("rsp_in_first_gap", rsp_timing_bad, 0);

        // 5: reset during the 5th SHIFT cycle of a read-data frame
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = 10'h300;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midframe_active", ss_n, 0);
        r0 = rsp_cnt;
        rst_n = 1'b0;
        #1;
        check("midframe_ssn_async", ss_n, 1);
        check("midframe_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midframe_no_rsp", rsp_cnt - r0, 0);
        check("midframe_rsp_data", rsp_data, 8'h00);
        check("midframe_ready", cmd_ready, 1);
        r0 = rsp_cnt;
        send(10'h300);
        check("after_reset_len", last_len, 21);
        check("after_reset_pulses", rsp_cnt - r0, 1);
        check("after_reset_data", rsp_data, 8'h33);

        // 6: RD_TURNAROUND=3 instance, slave returns 0x5A
        g = 0;
        @(negedge clk);
        while (!cmd_ready3 && g < 200) begin
            @(negedge clk);
            g++;
        end
        cmd_valid3 = 1'b1;
        cmd_data3  = 10'h300;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        g = 0;
        while (busy3 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("t3_done", (g < 200), 1);
        check("t3_len", last_len3, 22);
        check("t3_pulses", rsp_cnt3, 1);
        check("t3_rsp_data", rsp_data3, 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
